// File: rtl/systolic_skew_feeder.sv
// ============================================================================
// Module   : systolic_skew_feeder
// Purpose  : Upstream operand feeder for an N x N systolic MAC array. Holds
//            one N x N matrix A (left-edge operand) and one N x N matrix B
//            (top-edge operand). On start it clears the PE accumulators, then
//            streams A rows and B columns with diagonal skew, pads with zeros
//            while the last products propagate, and pulses done.
// Ports    : clk, reset (sync, active-high)
//            wr_en/wr_sel/wr_row/wr_col/wr_data : buffer write port (IDLE only)
//            start    : begin a feed sequence (accepted in IDLE only)
//            busy     : high from CLEAR through DONE
//            done     : one-cycle completion pulse
//            pe_clear : one-cycle accumulator clear
//            a_edge   : slice i feeds in_a of PE(i,0)
//            b_edge   : slice j feeds in_b of PE(0,j)
//            err      : (SKEW_FEEDER_ERR_EN only) sticky illegal-request flag
// Options  : `define SKEW_FEEDER_ERR_EN adds the err output.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module systolic_skew_feeder #(
    parameter  int data_size = 8,
    parameter  int N         = 4,
    localparam int ADDR_W    = $clog2(N)
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   wr_en,
    input  logic                   wr_sel,
    input  logic [ADDR_W-1:0]      wr_row,
    input  logic [ADDR_W-1:0]      wr_col,
    input  logic [data_size-1:0]   wr_data,
    input  logic                   start,
    output logic                   busy,
    output logic                   done,
`ifdef SKEW_FEEDER_ERR_EN
    output logic                   err,
`endif
    output logic                   pe_clear,
    output logic [N*data_size-1:0] a_edge,
    output logic [N*data_size-1:0] b_edge
);

    // Counter must hold 2N-2 (last STREAM index); sized for 2N-1.
    localparam int CNT_W = $clog2(2 * N);
    localparam logic [CNT_W-1:0] STREAM_LAST = CNT_W'(2 * N - 2);
    localparam logic [CNT_W-1:0] DRAIN_LAST  = CNT_W'(N - 1);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        CLEAR  = 3'd1,
        STREAM = 3'd2,
        DRAIN  = 3'd3,
        DONE   = 3'd4
    } state_t;

    state_t               state, state_next;
    logic [CNT_W-1:0]     t, t_next;
    logic [N*data_size-1:0] a_next, b_next;

    logic [data_size-1:0] a_mem [N][N];
    logic [data_size-1:0] b_mem [N][N];

    // Operand buffers: no reset, writable only while idle.
    always_ff @(posedge clk) begin
        if (state == IDLE && wr_en) begin
            if (wr_sel) b_mem[wr_row][wr_col] <= wr_data;
            else        a_mem[wr_row][wr_col] <= wr_data;
        end
    end

    // Next-state and counter logic. The counter restarts at 0 on every
    // state change so each state sees its own local index.
    always_comb begin
        state_next = state;
        t_next     = '0;
        case (state)
            IDLE:   if (start) state_next = CLEAR;
            CLEAR:  state_next = STREAM;
            STREAM: begin
                if (t == STREAM_LAST) state_next = DRAIN;
                else                  t_next     = t + CNT_W'(1);
            end
            DRAIN: begin
                if (t == DRAIN_LAST) state_next = DONE;
                else                 t_next     = t + CNT_W'(1);
            end
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Edge values are computed from the *next* state and index so that the
    // registered outputs line up with the cycles the state occupies.
    for (genvar i = 0; i < N; i++) begin : g_edge
        logic [data_size-1:0] a_sel, b_sel;
        always_comb begin
            int d;
            a_sel = '0;
            b_sel = '0;
            d     = int'(t_next) - i;
            if (state_next == STREAM && d >= 0 && d < N) begin
                a_sel = a_mem[i][d[ADDR_W-1:0]];
                b_sel = b_mem[d[ADDR_W-1:0]][i];
            end
        end
        assign a_next[i*data_size +: data_size] = a_sel;
        assign b_next[i*data_size +: data_size] = b_sel;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            t        <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
            pe_clear <= 1'b0;
            a_edge   <= '0;
            b_edge   <= '0;
        end else begin
            state    <= state_next;
            t        <= t_next;
            busy     <= (state_next != IDLE);
            done     <= (state_next == DONE);
            pe_clear <= (state_next == CLEAR);
            a_edge   <= a_next;
            b_edge   <= b_next;
        end
    end

`ifdef SKEW_FEEDER_ERR_EN
    // Any write or start request seen while busy is an illegal request.
    always_ff @(posedge clk) begin
        if (reset)                      err <= 1'b0;
        else if (busy && (wr_en || start)) err <= 1'b1;
    end
`endif

endmodule

`default_nettype wire

// File: tb/tb_systolic_skew_feeder.sv
// ============================================================================
// Module   : tb_systolic_skew_feeder
// Purpose  : Self-checking bench for systolic_skew_feeder (N=4, data_size=8).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_systolic_skew_feeder;

    localparam int N  = 4;
    localparam int DW = 8;

    logic           clk = 1'b0;
    logic           reset = 1'b1;
    logic           wr_en = 1'b0;
    logic           wr_sel = 1'b0;
    logic [1:0]     wr_row = '0;
    logic [1:0]     wr_col = '0;
    logic [DW-1:0]  wr_data = '0;
    logic           start = 1'b0;
    logic           busy, done, pe_clear;
    logic [N*DW-1:0] a_edge, b_edge;
`ifdef SKEW_FEEDER_ERR_EN
    logic           err;
`endif

    int n_tests = 0;
    int n_fail  = 0;

    logic [DW-1:0] ma [N][N];
    logic [DW-1:0] mb [N][N];

    always #5 clk = ~clk;

    systolic_skew_feeder #(.data_size(DW), .N(N)) dut (
        .clk      (clk),
        .reset    (reset),
        .wr_en    (wr_en),
        .wr_sel   (wr_sel),
        .wr_row   (wr_row),
        .wr_col   (wr_col),
        .wr_data  (wr_data),
        .start    (start),
        .busy     (busy),
        .done     (done),
`ifdef SKEW_FEEDER_ERR_EN
        .err      (err),
`endif
        .pe_clear (pe_clear),
        .a_edge   (a_edge),
        .b_edge   (b_edge)
    );

    typedef struct {
        int          k;
        logic        clr;
        logic        bsy;
        logic        dn;
        logic [31:0] a;
        logic [31:0] b;
    } vec_t;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual=%0h required=%0h", nm, act, exp);
        end
    endtask

    task automatic wr(input logic sel, input int r, input int c, input logic [DW-1:0] d);
        wr_en = 1'b1; wr_sel = sel; wr_row = 2'(r); wr_col = 2'(c); wr_data = d;
        tick();
        wr_en = 1'b0;
        if (sel) mb[r][c] = d; else ma[r][c] = d;
    endtask

    // Reference model: cycle k after the start-accept edge.
    // k=1 CLEAR, k=2..2N STREAM (t=k-2), next N cycles DRAIN, then DONE.
    function automatic logic [31:0] exp_a(int k);
        logic [31:0] r = '0;
        int t = k - 2;
        if (k >= 2 && k <= 2 * N)
            for (int i = 0; i < N; i++)
                if (t - i >= 0 && t - i < N) r[i*DW +: DW] = ma[i][t-i];
        return r;
    endfunction

    function automatic logic [31:0] exp_b(int k);
        logic [31:0] r = '0;
        int t = k - 2;
        if (k >= 2 && k <= 2 * N)
            for (int j = 0; j < N; j++)
                if (t - j >= 0 && t - j < N) r[j*DW +: DW] = mb[t-j][j];
        return r;
    endfunction

    localparam int K_DONE = 1 + (2 * N - 1) + N + 1;  // 13 for N=4

    // mode 0: quiet; 1: write A[0][0]=99 + start at STREAM t=2; 2: random noise
    task automatic run(input int mode, input string tag);
        start = 1'b1;
        tick();
        start = 1'b0;
        wr_en = 1'b0;
        for (int k = 1; k <= K_DONE + 1; k++) begin
            chk($sformatf("%s_clr_k%0d", tag, k), 32'(pe_clear), 32'(k == 1));
            chk($sformatf("%s_busy_k%0d", tag, k), 32'(busy), 32'(k >= 1 && k <= K_DONE));
            chk($sformatf("%s_done_k%0d", tag, k), 32'(done), 32'(k == K_DONE));
            chk($sformatf("%s_a_k%0d", tag, k), a_edge, exp_a(k));
            chk($sformatf("%s_b_k%0d", tag, k), b_edge, exp_b(k));
            wr_en = 1'b0; start = 1'b0;
            if (mode == 1 && k == 4) begin
                wr_en = 1'b1; wr_sel = 1'b0; wr_row = 2'd0; wr_col = 2'd0;
                wr_data = 8'd99; start = 1'b1;
            end else if (mode == 2 && k <= K_DONE - 1) begin
                wr_en   = 1'($urandom_range(0, 1));
                wr_sel  = 1'($urandom_range(0, 1));
                wr_row  = 2'($urandom_range(0, 3));
                wr_col  = 2'($urandom_range(0, 3));
                wr_data = 8'($urandom);
                start   = 1'($urandom_range(0, 1));
            end
            tick();
        end
        wr_en = 1'b0; start = 1'b0;
    endtask

    vec_t tbl [14];

    initial begin
        // Hand-derived expectations for A[i][k]=4i+k+1, B=identity.
        tbl[0]  = '{1,  1'b1, 1'b1, 1'b0, 32'h00000000, 32'h00000000};
        tbl[1]  = '{2,  1'b0, 1'b1, 1'b0, 32'h00000001, 32'h00000001};
        tbl[2]  = '{3,  1'b0, 1'b1, 1'b0, 32'h00000502, 32'h00000000};
        tbl[3]  = '{4,  1'b0, 1'b1, 1'b0, 32'h00090603, 32'h00000100};
        tbl[4]  = '{5,  1'b0, 1'b1, 1'b0, 32'h0D0A0704, 32'h00000000};
        tbl[5]  = '{6,  1'b0, 1'b1, 1'b0, 32'h0E0B0800, 32'h00010000};
        tbl[6]  = '{7,  1'b0, 1'b1, 1'b0, 32'h0F0C0000, 32'h00000000};
        tbl[7]  = '{8,  1'b0, 1'b1, 1'b0, 32'h10000000, 32'h01000000};
        tbl[8]  = '{9,  1'b0, 1'b1, 1'b0, 32'h00000000, 32'h00000000};
        tbl[9]  = '{10, 1'b0, 1'b1, 1'b0, 32'h00000000, 32'h00000000};
        tbl[10] = '{11, 1'b0, 1'b1, 1'b0, 32'h00000000, 32'h00000000};
        tbl[11] = '{12, 1'b0, 1'b1, 1'b0, 32'h00000000, 32'h00000000};
        tbl[12] = '{13, 1'b0, 1'b1, 1'b1, 32'h00000000, 32'h00000000};
        tbl[13] = '{14, 1'b0, 1'b0, 1'b0, 32'h00000000, 32'h00000000};

        // Reset state
        tick(); tick();
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_clr", 32'(pe_clear), 32'd0);
        chk("rst_a", a_edge, 32'd0);
        chk("rst_b", b_edge, 32'd0);
        reset = 1'b0;
        tick();

        // Scenario 1/2: table-driven fixed pattern
        for (int i = 0; i < N; i++)
            for (int k = 0; k < N; k++) begin
                wr(1'b0, i, k, 8'(4 * i + k + 1));
                wr(1'b1, i, k, (i == k) ? 8'd1 : 8'd0);
            end
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int v = 0; v < 14; v++) begin
            chk($sformatf("tbl_clr_k%0d", tbl[v].k), 32'(pe_clear), 32'(tbl[v].clr));
            chk($sformatf("tbl_busy_k%0d", tbl[v].k), 32'(busy), 32'(tbl[v].bsy));
            chk($sformatf("tbl_done_k%0d", tbl[v].k), 32'(done), 32'(tbl[v].dn));
            chk($sformatf("tbl_a_k%0d", tbl[v].k), a_edge, tbl[v].a);
            chk($sformatf("tbl_b_k%0d", tbl[v].k), b_edge, tbl[v].b);
            tick();
        end

        // Scenario 4: write + restart attempt mid-STREAM, then a clean rerun
        run(1, "s4_busy");
        run(0, "s4_rerun");
`ifdef SKEW_FEEDER_ERR_EN
        chk("s4_err_set", 32'(err), 32'd1);
`endif

        // Scenario 5: reset at STREAM t=2, then rerun with unchanged buffers
        start = 1'b1;
        tick();
        start = 1'b0;
        tick(); tick(); tick();              // cycle 4 = STREAM t=2
        chk("s5_pre_a", a_edge, exp_a(4));
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("s5_busy", 32'(busy), 32'd0);
        chk("s5_a", a_edge, 32'd0);
        chk("s5_b", b_edge, 32'd0);
        chk("s5_clr", 32'(pe_clear), 32'd0);
`ifdef SKEW_FEEDER_ERR_EN
        chk("s5_err_clr", 32'(err), 32'd0);
`endif
        for (int c = 0; c < 14; c++) begin
            chk($sformatf("s5_nodone_c%0d", c), 32'(done), 32'd0);
            tick();
        end
        run(0, "s5_rerun");

        // Scenario 6: write B[0][0]=5 in the same cycle as start
        wr_en = 1'b1; wr_sel = 1'b1; wr_row = 2'd0; wr_col = 2'd0; wr_data = 8'd5;
        mb[0][0] = 8'd5;
        start = 1'b1;
        tick();
        start = 1'b0; wr_en = 1'b0;
        tick();
        chk("s6_b00", 32'(b_edge[7:0]), 32'd5);
        for (int c = 0; c < 14; c++) tick();

        // Randomized matrices with random illegal requests while busy
        for (int it = 0; it < 3; it++) begin
            for (int i = 0; i < N; i++)
                for (int k = 0; k < N; k++) begin
                    wr(1'b0, i, k, 8'($urandom));
                    wr(1'b1, i, k, 8'($urandom));
                end
            run(2, $sformatf("rnd%0d", it));
            tick();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
